// File: rtl/multiport_register_file.sv
// Multi-ported register file with registered reads, same-cycle write bypass
// and a per-register busy scoreboard for pending writebacks.
module multiport_register_file #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(NUM_REGS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*XLEN-1:0]   wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr
);

   logic [XLEN-1:0]     regs     [NUM_REGS];
   logic [XLEN-1:0]     data_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   // Post-edge state of every register; reads sample this so bypass and
   // reserve-over-write precedence fall out of one computation.
   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         data_nxt[r] = regs[r];
      end
      busy_nxt = busy;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
         if (wr_en[w] && (ZERO_REG == 0 || wr_addr[w*AW +: AW] != '0)) begin
            data_nxt[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
         end
      end
      if (rsv_en && (ZERO_REG == 0 || rsv_addr != '0)) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
         busy    <= '0;
         rd_data <= '0;
         rd_busy <= '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs[r] <= data_nxt[r];
         end
         busy <= busy_nxt;
         for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
               rd_data[p*XLEN +: XLEN] <= data_nxt[rd_addr[p*AW +: AW]];
               rd_busy[p]              <= busy_nxt[rd_addr[p*AW +: AW]];
            end
         end
      end
   end

endmodule
